// File: rtl/bcd_to_bin_if.sv
// Handshake bundle for the BCD-to-binary converter: the request side (BCD in) and the
// response side (binary out), each with its own valid/ready pair.
interface bcd_to_bin_if #(
  parameter int unsigned DIGITS = 5,
  parameter int unsigned OUT_W  = 17
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  in_neg;
  logic                  out_valid;
  logic                  out_ready;
  logic [OUT_W-1:0]      out_bin;
  logic                  out_ovf;
  logic                  out_err;

  modport master (
    output in_valid, in_bcd, in_neg, out_ready,
    input  in_ready, out_valid, out_bin, out_ovf, out_err
  );

  modport slave (
    input  in_valid, in_bcd, in_neg, out_ready,
    output in_ready, out_valid, out_bin, out_ovf, out_err
  );
endinterface

// File: rtl/bcd_to_bin.sv
// Sign + packed-BCD magnitude to two's-complement binary, one digit per clock (MSD first),
// with saturation on range overflow and a sticky error flag for non-decimal digits.
module bcd_to_bin #(
  parameter int unsigned DIGITS = 5,
  parameter int unsigned OUT_W  = 17
) (
  input logic          clk,
  input logic          rst,
  bcd_to_bin_if.slave  bus
);

  localparam int unsigned BcdW   = 4 * DIGITS;
  // 16^D > 10^D, so the BCD width also holds the largest decimal magnitude without wrap.
  localparam int unsigned AccW   = BcdW;
  localparam int unsigned CntW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned PosMax = (1 << (OUT_W - 1)) - 1;
  localparam int unsigned NegMax = (1 << (OUT_W - 1));

  typedef enum logic [1:0] {StIdle, StConv, StHold} state_e;

  state_e            state_q;
  logic [BcdW-1:0]   bcd_q;
  logic              neg_q;
  logic [AccW-1:0]   acc_q;
  logic [CntW-1:0]   cnt_q;
  logic              err_q;

  logic [3:0]        digit;
  logic [AccW-1:0]   acc_nxt;
  logic              err_nxt;
  logic [OUT_W-1:0]  mag;
  logic [OUT_W-1:0]  bin_d;
  logic              ovf_d;

  always_comb begin
    digit   = bcd_q[BcdW-1 -: 4];
    acc_nxt = (acc_q << 3) + (acc_q << 1) + AccW'(digit);
    err_nxt = err_q | (digit > 4'd9);
    mag     = OUT_W'(acc_nxt);
    bin_d   = '0;
    ovf_d   = 1'b0;
    if (err_nxt) begin
      bin_d = '0;
    end else if (!neg_q && (32'(acc_nxt) > PosMax)) begin
      bin_d = OUT_W'(PosMax);
      ovf_d = 1'b1;
    end else if (neg_q && (32'(acc_nxt) > NegMax)) begin
      bin_d = {1'b1, {(OUT_W - 1){1'b0}}};
      ovf_d = 1'b1;
    end else begin
      bin_d = neg_q ? -mag : mag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      bcd_q         <= '0;
      neg_q         <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      err_q         <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_bin   <= '0;
      bus.out_ovf   <= 1'b0;
      bus.out_err   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.in_valid) begin
            bcd_q        <= bus.in_bcd;
            neg_q        <= bus.in_neg;
            acc_q        <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            bus.in_ready <= 1'b0;
            state_q      <= StConv;
          end
        end
        StConv: begin
          acc_q <= acc_nxt;
          err_q <= err_nxt;
          bcd_q <= bcd_q << 4;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntW'(DIGITS - 1)) begin
            bus.out_bin   <= bin_d;
            bus.out_ovf   <= ovf_d;
            bus.out_err   <= err_nxt;
            bus.out_valid <= 1'b1;
            state_q       <= StHold;
          end
        end
        StHold: begin
          // in_ready only rises after the output handshake, so no accept at that edge.
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state_q       <= StIdle;
          end
        end
        default: begin
          state_q       <= StIdle;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed bench for bcd_to_bin: reset state, conversions, range limits, digit errors,
// output stall, back-to-back handshake and mid-conversion reset.
module tb_bcd_to_bin;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  bcd_to_bin_if #(.DIGITS(5), .OUT_W(17)) bus ();

  bcd_to_bin #(.DIGITS(5), .OUT_W(17)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one input, wait for acceptance, then scramble the bus to prove it was latched.
  task automatic send(input logic [19:0] bcd, input logic neg);
    int n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_bcd   = bcd;
    bus.in_neg   = neg;
    step();
    bus.in_valid = 1'b0;
    bus.in_bcd   = 20'hFFFFF;
    bus.in_neg   = ~neg;
  endtask

  task automatic wait_out(input string tag);
    int lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'd5);
  endtask

  task automatic convert(input string tag, input logic [19:0] bcd, input logic neg,
                         input logic [16:0] exp_bin, input logic exp_ovf, input logic exp_err,
                         input int hold);
    send(bcd, neg);
    wait_out(tag);
    check({tag, "_bin"}, 32'(bus.out_bin), 32'(exp_bin));
    check({tag, "_ovf"}, 32'(bus.out_ovf), 32'(exp_ovf));
    check({tag, "_err"}, 32'(bus.out_err), 32'(exp_err));
    for (int i = 0; i < hold; i++) begin
      step();
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_bin"},   32'(bus.out_bin),   32'(exp_bin));
      check({tag, "_hold_err"},   32'(bus.out_err),   32'(exp_err));
      check({tag, "_hold_ovf"},   32'(bus.out_ovf),   32'(exp_ovf));
      check({tag, "_hold_ready"}, 32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.in_neg    = 1'b0;
    bus.out_ready = 1'b0;

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_bin",   32'(bus.out_bin),   32'd0);
    check("rst_out_ovf",   32'(bus.out_ovf),   32'd0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);

    // Basic conversions
    convert("pos12345", 20'h12345, 1'b0, 17'h03039, 1'b0, 1'b0, 0);
    convert("neg42",    20'h00042, 1'b1, 17'h1FFD6, 1'b0, 1'b0, 0);
    convert("negzero",  20'h00000, 1'b1, 17'h00000, 1'b0, 1'b0, 0);
    convert("neg1",     20'h00001, 1'b1, 17'h1FFFF, 1'b0, 1'b0, 0);

    // Range boundaries
    convert("pos65535", 20'h65535, 1'b0, 17'h0FFFF, 1'b0, 1'b0, 0);
    convert("pos65536", 20'h65536, 1'b0, 17'h0FFFF, 1'b1, 1'b0, 0);
    convert("neg65536", 20'h65536, 1'b1, 17'h10000, 1'b0, 1'b0, 0);
    convert("neg65537", 20'h65537, 1'b1, 17'h10000, 1'b1, 1'b0, 0);
    convert("neg99999", 20'h99999, 1'b1, 17'h10000, 1'b1, 1'b0, 0);
    convert("pos99999", 20'h99999, 1'b0, 17'h0FFFF, 1'b1, 1'b0, 0);

    // Bad digits, including an error that would also overflow; stall on the first
    convert("err1A234", 20'h1A234, 1'b0, 17'h00000, 1'b0, 1'b1, 7);
    convert("err0000F", 20'h0000F, 1'b1, 17'h00000, 1'b0, 1'b1, 0);
    convert("errF9999", 20'hF9999, 1'b0, 17'h00000, 1'b0, 1'b1, 0);

    // Back-to-back: second input held across the output handshake
    send(20'h00100, 1'b0);
    wait_out("b2b_first");
    check("b2b_first_bin", 32'(bus.out_bin), 32'h64);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bcd    = 20'h00777;
    bus.in_neg    = 1'b0;
    step();
    bus.out_ready = 1'b0;
    check("b2b_m_valid", 32'(bus.out_valid), 32'd0);
    check("b2b_m_ready", 32'(bus.in_ready),  32'd1);
    step();
    bus.in_valid = 1'b0;
    bus.in_bcd   = 20'hFFFFF;
    check("b2b_accept", 32'(bus.in_ready), 32'd0);
    wait_out("b2b_second");
    check("b2b_second_bin", 32'(bus.out_bin), 32'h309);
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
    check("b2b_release", 32'(bus.out_valid), 32'd0);

    // Reset asserted at edge N+3 of a conversion aborts it
    send(20'h54321, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step();
      check("abort_quiet", 32'(bus.out_valid), 32'd0);
    end
    convert("post_abort", 20'h00100, 1'b1, 17'h1FF9C, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
